// File: rtl/memory_access_stage.sv
// Memory access (MEM) stage of the pipeline.
// Turns a load/store from the EX/MEM register into a single request/acknowledge
// transaction on the data-memory port. The earlier pipeline stages stall while
// the access is in flight. Load data is lane-selected and extended before it
// reaches the MEM/WB register.
// Optional feature: define MEMORY_ACCESS_STAGE_ALIGN_CHECK_EN to detect
// misaligned halfword/word accesses. Such an access is suppressed and flagged
// on misalignedAccess.
module memory_access_stage (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_shouldReadMemory,
   input  logic        mem_shouldWriteMemory,
   input  logic [1:0]  mem_accessSize,
   input  logic        mem_signExtend,
   input  logic [31:0] mem_aluOutput,
   input  logic [31:0] mem_storeData,
   input  logic        mem_shouldWriteRegister,
   output logic        dmem_request,
   output logic        dmem_writeEnable,
   output logic [31:0] dmem_address,
   output logic [3:0]  dmem_byteEnable,
   output logic [31:0] dmem_writeData,
   input  logic        dmem_acknowledge,
   input  logic [31:0] dmem_readData,
   output logic        stall,
   output logic        wbValid_shouldWriteRegister,
`ifdef MEMORY_ACCESS_STAGE_ALIGN_CHECK_EN
   output logic        misalignedAccess,
`endif
   output logic [31:0] mem_memoryData
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;

   state_t      state;
   state_t      next_state;
   logic        access_present;
   logic        suppressed;
   logic        start_access;
   logic        finish_access;
   logic [3:0]  lane_enable;
   logic [31:0] lane_data;
   logic [31:0] load_value;
   logic [31:0] byte_shifted;
   logic [31:0] half_shifted;

   // A store wins when both request bits are set, so the write bit alone
   // selects the direction.
   assign access_present = mem_shouldReadMemory | mem_shouldWriteMemory;

`ifdef MEMORY_ACCESS_STAGE_ALIGN_CHECK_EN
   logic misaligned;

   // Alignment rule: halfwords need addr[0]=0 and words need addr[1:0]=00.
   // Size 11 behaves as a word.
   always_comb begin
      case (mem_accessSize)
         SIZE_BYTE: misaligned = 1'b0;
         SIZE_HALF: misaligned = mem_aluOutput[0];
         default:   misaligned = (mem_aluOutput[1:0] != 2'b00);
      endcase
   end

   assign suppressed = access_present & misaligned;
`else
   assign suppressed = 1'b0;
`endif

   // Byte enables and lane-replicated store data for the current access size.
   always_comb begin
      case (mem_accessSize)
         SIZE_BYTE: begin
            lane_enable = 4'b0001 << mem_aluOutput[1:0];
            lane_data   = {4{mem_storeData[7:0]}};
         end
         SIZE_HALF: begin
            lane_enable = 4'b0011 << {mem_aluOutput[1], 1'b0};
            lane_data   = {2{mem_storeData[15:0]}};
         end
         default: begin
            lane_enable = 4'b1111;
            lane_data   = mem_storeData;
         end
      endcase
   end

   // Select the addressed lane(s) of the returned word and extend to 32 bits.
   always_comb begin
      byte_shifted = dmem_readData >> {mem_aluOutput[1:0], 3'b000};
      half_shifted = dmem_readData >> {mem_aluOutput[1], 4'b0000};
      case (mem_accessSize)
         SIZE_BYTE: load_value = {{24{mem_signExtend & byte_shifted[7]}},  byte_shifted[7:0]};
         SIZE_HALF: load_value = {{16{mem_signExtend & half_shifted[15]}}, half_shifted[15:0]};
         default:   load_value = dmem_readData;
      endcase
   end

   // Next-state logic together with the stall and write-back qualifiers.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      next_state    = state;
      stall         = 1'b0;
      start_access  = 1'b0;
      finish_access = 1'b0;
      case (state)
         IDLE: begin
            if (access_present && !suppressed) begin
               stall        = 1'b1;
               start_access = 1'b1;
               next_state   = REQUEST;
            end
         end
         REQUEST: begin
            stall = 1'b1;
            if (dmem_acknowledge) begin
               finish_access = 1'b1;
               next_state    = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      wbValid_shouldWriteRegister = mem_shouldWriteRegister & ~stall & ~suppressed;
   end

   // The request line is high exactly while the transaction is outstanding.
   assign dmem_request = (state == REQUEST);

   // State register plus the memory-port and read-data registers.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before this edge.
      if (reset) begin
         // NOTE: the datapath registers are also cleared on reset so the
         // memory port reads all-zero in the first cycle after reset.
         state            <= IDLE;
         dmem_writeEnable <= 1'b0;
         dmem_address     <= 32'd0;
         dmem_byteEnable  <= 4'd0;
         dmem_writeData   <= 32'd0;
         mem_memoryData   <= 32'd0;
      end else begin
         state <= next_state;
         if (start_access) begin
            dmem_writeEnable <= mem_shouldWriteMemory;
            dmem_address     <= {mem_aluOutput[31:2], 2'b00};
            dmem_byteEnable  <= lane_enable;
            dmem_writeData   <= lane_data;
         end else if (finish_access) begin
            dmem_writeEnable <= 1'b0;
         end
         if (finish_access) begin
            mem_memoryData <= mem_shouldWriteMemory ? 32'd0 : load_value;
         end
      end
   end

`ifdef MEMORY_ACCESS_STAGE_ALIGN_CHECK_EN
   // Flag a suppressed misaligned access for the single cycle after it was seen.
   always_ff @(posedge clock) begin
      if (reset) begin
         misalignedAccess <= 1'b0;
      end else begin
         misalignedAccess <= (state == IDLE) && suppressed;
      end
   end
`endif

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 The block SHALL use: reset reset, synchronous, active-high; clock clock.
REQ-002 clock  in  1  pipeline clock, all state on rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 mem_shouldReadMemory / mem_shouldWriteMemory  in  1 each  load / store request from the EX/MEM register; both high is treated as store.
REQ-005 mem_accessSize  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-006 mem_signExtend  in  1  load sign-extends (1) or zero-extends (0).
REQ-007 mem_aluOutput  in  32  effective address; mem_storeData  in  32  store operand.
REQ-008 mem_shouldWriteRegister  in  1  instruction writes the register file.
REQ-009 dmem_request  out  1; dmem_writeEnable  out  1; dmem_address  out  32 (word-aligned, bits[1:0]=00); dmem_byteEnable  out  4; dmem_writeData  out  32.
REQ-010 dmem_acknowledge  in  1; dmem_readData  in  32  data memory response.
REQ-011 stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-012 wbValid_shouldWriteRegister  out  1  mem_shouldWriteRegister gated to 0 while stall is high or the access is suppressed.
REQ-013 mem_memoryData  out  32  aligned, extended load result for the MEM/WB register.
REQ-014 misalignedAccess  out  1  one-cycle pulse (present only with the macro of REQ-033).

Function
REQ-015 FSM states IDLE, REQUEST, DONE; state and all registered outputs update on the rising edge only.
REQ-016 IDLE, no load/store: stall=0, dmem_request=0, wbValid_shouldWriteRegister=mem_shouldWriteRegister, next IDLE.
REQ-017 IDLE, load or store present: stall=1, wbValid_shouldWriteRegister=0, next REQUEST.
REQ-018 REQUEST: dmem_request=1, stall=1; address, byteEnable, writeData and writeEnable held constant until dmem_acknowledge.
REQ-019 REQUEST with dmem_acknowledge=1: load data captured into the internal read register, next DONE; without acknowledge, stay in REQUEST indefinitely.
REQ-020 DONE: stall=0, dmem_request=0, wbValid_shouldWriteRegister=mem_shouldWriteRegister, mem_memoryData from the read register; next IDLE unconditionally.
REQ-021 Minimum latency of a memory instruction is 3 cycles (IDLE, REQUEST with acknowledge, DONE); each further wait cycle adds one.
REQ-022 Byte enables (little-endian): byte 4'b0001<<addr[1:0]; halfword 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-023 Store data is replicated across lanes: byte {4{d[7:0]}}, halfword {2{d[15:0]}}, word d.
REQ-024 Load data is selected from the lane(s) given by addr[1:0] and extended to 32 bits per mem_signExtend; word loads are not extended.
REQ-025 dmem_acknowledge in IDLE or DONE is ignored and changes no state.
REQ-026 For a store, mem_memoryData is 0 in DONE.
REQ-027 Back-to-back memory instructions: the second is seen in IDLE after DONE and starts a fresh 3-cycle sequence; no access is issued twice.

Reset
REQ-028 On reset the FSM SHALL enter IDLE; the next cycle shows stall=0, dmem_request=0, dmem_writeEnable=0, dmem_byteEnable=0, dmem_address=0, dmem_writeData=0, read register=0, misalignedAccess=0.
REQ-029 Reset during REQUEST abandons the access; an acknowledge arriving after reset is ignored per REQ-025.
REQ-030 Reset has priority over every other event in the same cycle.

Configuration
REQ-031 A halfword with addr[0]=1, or a word with addr[1:0]!=00, is misaligned.
REQ-032 Without the macro, misaligned addresses are not checked; the lane shifts of REQ-022/024 apply, with bits truncated to 4 lanes.
REQ-033 With MEMORY_ACCESS_STAGE_ALIGN_CHECK_EN defined, a misaligned access in IDLE SHALL pulse misalignedAccess for one cycle, issue no request, keep stall=0, force wbValid_shouldWriteRegister=0, and stay in IDLE.

Verification
REQ-034 Word load addr 0x100, acknowledge in the 1st REQUEST cycle, readData 0xDEADBEEF -> stall high 2 cycles, mem_memoryData=0xDEADBEEF in DONE, byteEnable=1111.
REQ-035 Signed byte load addr 0x203, readData 0x80112233 -> byteEnable=1000, mem_memoryData=0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 Halfword store addr 0x302, data 0x0000ABCD, acknowledge after 3 wait cycles -> writeData=0xABCDABCD, byteEnable=1100, address=0x300, stall high 5 cycles, request held stable.
REQ-037 Reset asserted in REQUEST, acknowledge one cycle later -> IDLE, request 0, no state change from the late acknowledge.
REQ-038 With macro, word load addr 0x102 -> misalignedAccess one-cycle pulse, dmem_request never asserted, wbValid_shouldWriteRegister=0.
